// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB) control FSM.
// Optional macro ILLEGAL_TRAP_EN: an illegal opcode traps into HALT instead of executing as a NOP.
module instr_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        alu_src_imm,
    output logic        reg_we,
    output logic        wb_sel_mem,
    output logic [2:0]  state,
    output logic        trap
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Reset value of ir is the canonical NOP (addi x0,x0,0).
    localparam logic [31:0] IR_NOP = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;

    logic is_load, is_op_imm, is_store, is_op;

    always_comb begin
        is_load   = (ir_q[6:0] == OPC_LOAD);
        is_op_imm = (ir_q[6:0] == OPC_OP_IMM);
        is_store  = (ir_q[6:0] == OPC_STORE);
        is_op     = (ir_q[6:0] == OPC_OP);
    end

`ifdef ILLEGAL_TRAP_EN
    logic trap_q, trap_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= IR_NOP;
`ifdef ILLEGAL_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
`ifdef ILLEGAL_TRAP_EN
            trap_q  <= trap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
`ifdef ILLEGAL_TRAP_EN
        trap_d  = trap_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_op || is_op_imm) begin
                    state_d = S_WB;
                end else begin
`ifdef ILLEGAL_TRAP_EN
                    trap_d  = 1'b1;
                    state_d = S_HALT;
`else
                    pc_d    = pc_q + 32'd4;
                    state_d = S_FETCH;
`endif
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_q + 32'd4;
                state_d = S_FETCH;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                state_d = S_HALT;
`else
                state_d = S_FETCH;
`endif
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by rst so they drop the instant reset is asserted.
    always_comb begin
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: imem_req = 1'b1;
                S_EXEC:  alu_src_imm = is_load || is_op_imm || is_store;
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                S_WB: begin
                    reg_we     = (ir_q[11:7] != 5'd0);
                    wb_sel_mem = is_load;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc    = pc_q;
        ir    = ir_q;
        state = state_q;
`ifdef ILLEGAL_TRAP_EN
        trap  = trap_q;
`else
        trap  = 1'b0;
`endif
    end

endmodule
